// File: rtl/dmem_port_if.sv
// ----------------------------------------------------------------------------
// dmem_port_if
// Data-cache handshake bundle between the MEM-stage responder and the cache.
//   dmem_read        : read strobe, held until dmem_resp
//   dmem_write       : write strobe, held until dmem_resp
//   dmem_byte_enable : active byte lanes of the word
//   dmem_address     : word-aligned byte address
//   dmem_wdata       : lane-shifted store data
//   dmem_resp        : single-cycle completion pulse from the cache
//   dmem_rdata       : read word, valid with dmem_resp
// master = pipeline-side responder, slave = data cache.
// ----------------------------------------------------------------------------
interface dmem_port_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_read,
        output dmem_write,
        output dmem_byte_enable,
        output dmem_address,
        output dmem_wdata,
        input  dmem_resp,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_read,
        input  dmem_write,
        input  dmem_byte_enable,
        input  dmem_address,
        input  dmem_wdata,
        output dmem_resp,
        output dmem_rdata
    );
endinterface

// File: rtl/dmem_port.sv
// ----------------------------------------------------------------------------
// dmem_port
// Turns a single-cycle MEM-stage load/store request into a held read/write
// handshake with the data cache and stalls the pipeline until the cache
// answers. Does store lane alignment, load extraction with sign/zero
// extension, and suppresses misaligned accesses.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   mem_read_i        : load request
//   mem_write_i       : store request (wins over mem_read_i)
//   funct3_i          : access width / extension
//   addr_i, wdata_i   : byte address, LSB-justified store data
//   stall_o           : hold pipeline (combinational)
//   load_data_o       : extended load result, valid in DONE
//   misaligned_o      : one-cycle pulse in DONE for a suppressed access
//   stall_count_o     : saturating count of stalled cycles
//   dmem              : cache handshake (master side)
// ----------------------------------------------------------------------------
module dmem_port #(
    parameter bit          CHECK_ALIGN = 1'b1,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [2:0]           funct3_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 stall_o,
    output logic [31:0]          load_data_o,
    output logic                 misaligned_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    dmem_port_if.master          dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width classes: 000/100 byte, 001/101 half, everything else word.
    function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return off[0];
            default:        return (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_be_f(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: return 4'b0001 << off;
            3'b001, 3'b101: return off[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data_f(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] wd);
        case (f3)
            3'b000, 3'b100: return {24'h000000, wd[7:0]} << {off, 3'b000};
            3'b001, 3'b101: return off[1] ? {wd[15:0], 16'h0000} : {16'h0000, wd[15:0]};
            default:        return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [31:0] byte_sh;
        logic [15:0] half;
        byte_sh = rd >> {off, 3'b000};
        half    = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  return {24'h000000, byte_sh[7:0]};
            3'b001:  return {{16{half[15]}}, half};
            3'b101:  return {16'h0000, half};
            default: return rd;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           load_q, load_d;
    logic                  mis_q, mis_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_s;
    logic                  stall_s;
    logic                  misalign_s;

    // Next-state, handshake and result logic.
    always_comb begin
        req_s      = mem_read_i | mem_write_i;
        stall_s    = req_s & (state_q != DONE);
        misalign_s = CHECK_ALIGN & misaligned_f(funct3_i, addr_i[1:0]);
        state_d    = state_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        off_d      = off_q;
        load_d     = load_q;
        mis_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_s && misalign_s) begin
                    // Suppressed access: straight to DONE, no cache traffic.
                    state_d = DONE;
                    mis_d   = 1'b1;
                    load_d  = 32'h0000_0000;
                end else if (req_s) begin
                    state_d = BUSY;
                    wr_d    = mem_write_i;
                    rd_d    = ~mem_write_i;
                    be_d    = store_be_f(funct3_i, addr_i[1:0]);
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = store_data_f(funct3_i, addr_i[1:0], wdata_i);
                    f3_d    = funct3_i;
                    off_d   = addr_i[1:0];
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (dmem.dmem_resp) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) begin
                        load_d = load_f(f3_q, off_q, dmem.dmem_rdata);
                    end else begin
                        load_d = load_q;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                // A request visible here belongs to the retiring instruction.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase

        if (stall_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers; reset abandons any cache transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            load_q  <= 32'h0000_0000;
            mis_q   <= 1'b0;
            cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            load_q  <= load_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_o               = stall_s;
    assign load_data_o           = load_q;
    assign misaligned_o          = mis_q;
    assign stall_count_o         = cnt_q;
    assign dmem.dmem_read        = rd_q;
    assign dmem.dmem_write       = wr_q;
    assign dmem.dmem_byte_enable = be_q;
    assign dmem.dmem_address     = addr_q;
    assign dmem.dmem_wdata       = wdata_q;

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;
    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        misaligned;
    logic [31:0] stall_count;
    int          pass_cnt;
    int          total_cnt;

    dmem_port_if bus ();

    dmem_port #(.CHECK_ALIGN(1'b1), .CNT_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .funct3_i      (funct3),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall),
        .load_data_o   (load_data),
        .misaligned_o  (misaligned),
        .stall_count_o (stall_count),
        .dmem          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
    endtask

    task automatic respond(input logic [31:0] rdv);
        bus.dmem_rdata = rdv;
        bus.dmem_resp  = 1'b1;
        tick();
        bus.dmem_resp  = 1'b0;
    endtask

    task automatic retire();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        rst            = 1'b1;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        funct3         = 3'b000;
        addr           = 32'h0;
        wdata          = 32'h0;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        tick();
        tick();
        check("rst_read",  {31'h0, bus.dmem_read}, 32'h0);
        check("rst_write", {31'h0, bus.dmem_write}, 32'h0);
        check("rst_load",  load_data, 32'h0);
        check("rst_mis",   {31'h0, misaligned}, 32'h0);
        check("rst_cnt",   stall_count, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;

        // sw 0x100, response on the third BUSY cycle
        start(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        check("sw_stall_c0", {31'h0, stall}, 32'h1);
        tick();
        check("sw_write_c1", {31'h0, bus.dmem_write}, 32'h1);
        check("sw_be",       {28'h0, bus.dmem_byte_enable}, 32'h0000_000F);
        check("sw_addr_c1",  bus.dmem_address, 32'h0000_0100);
        check("sw_wdata",    bus.dmem_wdata, 32'hDEAD_BEEF);
        tick();
        check("sw_write_c2", {31'h0, bus.dmem_write}, 32'h1);
        check("sw_addr_c2",  bus.dmem_address, 32'h0000_0100);
        tick();
        check("sw_write_c3", {31'h0, bus.dmem_write}, 32'h1);
        check("sw_stall_c3", {31'h0, stall}, 32'h1);
        respond(32'h0);
        check("sw_done_stall", {31'h0, stall}, 32'h0);
        check("sw_done_write", {31'h0, bus.dmem_write}, 32'h0);
        check("sw_cnt",        stall_count, 32'd4);
        retire();

        // lb / lbu from byte 3
        start(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0);
        tick();
        check("lb_read", {31'h0, bus.dmem_read}, 32'h1);
        check("lb_addr", bus.dmem_address, 32'h0000_0200);
        respond(32'h80FF_1234);
        check("lb_data", load_data, 32'hFFFF_FF80);
        retire();
        start(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0);
        tick();
        respond(32'h80FF_1234);
        check("lbu_data", load_data, 32'h0000_0080);
        check("lbu_cnt",  stall_count, 32'd8);
        retire();

        // sh / lhu on the upper half
        start(1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h0000_ABCD);
        tick();
        check("sh_be",    {28'h0, bus.dmem_byte_enable}, 32'h0000_000C);
        check("sh_wdata", bus.dmem_wdata, 32'hABCD_0000);
        respond(32'h0);
        retire();
        start(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0);
        tick();
        respond(32'hF00D_0000);
        check("lhu_data", load_data, 32'h0000_F00D);
        retire();

        // misaligned lw: no cache access, one-cycle flag
        start(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        check("mis_stall_c0", {31'h0, stall}, 32'h1);
        tick();
        check("mis_flag",  {31'h0, misaligned}, 32'h1);
        check("mis_stall", {31'h0, stall}, 32'h0);
        check("mis_read",  {31'h0, bus.dmem_read}, 32'h0);
        check("mis_load",  load_data, 32'h0);
        retire();
        check("mis_flag_off", {31'h0, misaligned}, 32'h0);
        check("mis_read_off", {31'h0, bus.dmem_read}, 32'h0);
        check("mis_cnt",      stall_count, 32'd13);

        // reset in the middle of a read
        start(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        tick();
        check("rb_read", {31'h0, bus.dmem_read}, 32'h1);
        rst = 1'b1;
        #1;
        check("rb_read_drop", {31'h0, bus.dmem_read}, 32'h0);
        check("rb_cnt",       stall_count, 32'h0);
        mem_read = 1'b0;
        rst      = 1'b0;
        respond(32'hAAAA_5555);
        check("rb_stray_read", {31'h0, bus.dmem_read}, 32'h0);
        check("rb_stray_load", load_data, 32'h0);
        start(1'b1, 1'b0, 3'b010, 32'h0000_0024, 32'h0);
        tick();
        check("rb_lw_addr", bus.dmem_address, 32'h0000_0024);
        respond(32'h1234_5678);
        check("rb_lw_data", load_data, 32'h1234_5678);
        check("rb_lw_cnt",  stall_count, 32'd2);
        retire();

        // read+write together is a write
        start(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D);
        tick();
        check("rw_write", {31'h0, bus.dmem_write}, 32'h1);
        check("rw_read",  {31'h0, bus.dmem_read}, 32'h0);
        check("rw_addr",  bus.dmem_address, 32'h0000_0040);
        respond(32'h0);
        retire();
        respond(32'hFFFF_FFFF);
        check("idle_resp_load",  load_data, 32'h1234_5678);
        check("idle_resp_write", {31'h0, bus.dmem_write}, 32'h0);
        check("idle_resp_stall", {31'h0, stall}, 32'h0);
        check("idle_resp_cnt",   stall_count, 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Data-memory responder for the control word's memory fields (mem_read, mem_write, funct3) issued by the control decoder in the MEM stage.
- Converts a single-cycle pipeline load/store request into a held read/write handshake with the data cache, and stalls the pipeline until the cache responds.
- Performs store byte-lane alignment, load extraction with sign/zero extension, and misalignment trapping.

Parameters:
- CHECK_ALIGN, 1, when 1 misaligned requests are suppressed and flagged; when 0 address bits [1:0] are used as given, with no check.
- CNT_WIDTH, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_read  in  1  load request from control word
- mem_write  in  1  store request from control word
- funct3  in  3  load/store width: lb=000, lh=001, lw=010, lbu=100, lhu=101; sb=000, sh=001, sw=010
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2), unaligned, LSB-justified
- stall  out  1  hold pipeline while high
- load_data  out  32  extended load result; valid only in the DONE cycle
- misaligned  out  1  one-cycle pulse in DONE for a suppressed misaligned access
- stall_count  out  CNT_WIDTH  count of cycles with stall=1
- dmem_read  out  1  cache read strobe (registered)
- dmem_write  out  1  cache write strobe (registered)
- dmem_byte_enable  out  4  byte lanes
- dmem_address  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-shifted store data
- dmem_resp  in  1  cache completion, single-cycle pulse
- dmem_rdata  in  32  cache read word, valid with dmem_resp

Behaviour:
- Reset (async):
  - state=IDLE; all registered outputs are 0, including dmem_*, load_data, misaligned and stall_count.
  - Reset during BUSY abandons the cache transaction; strobes drop immediately.
- req = mem_read | mem_write. When both are high, the request is a write and the read is ignored.
- stall = req & (state != DONE), combinational.
- States:
  - IDLE:
    - With req and an aligned address: latch address, byte enables and shifted wdata, then go to BUSY.
    - With req and a misaligned address (CHECK_ALIGN=1): go to DONE with the misaligned flag set and no cache access.
    - Without req: stay in IDLE.
  - BUSY:
    - dmem_read or dmem_write is asserted.
    - dmem_address, dmem_byte_enable and dmem_wdata are held stable.
    - On dmem_resp: capture the extended load result into load_data, deassert strobes in the same edge, go to DONE.
  - DONE:
    - Lasts exactly one cycle; stall=0 so the pipeline advances.
    - load_data and misaligned are valid; next state is IDLE.
    - A req seen during DONE belongs to the retiring instruction and is not accepted.
- Minimum latency: request at cycle 0, strobe visible at cycle 1, resp at cycle 1, DONE at cycle 2.
- dmem_resp in IDLE or DONE is ignored.
- Misaligned conditions: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0. load_data is 0 on a misaligned access.
- Store lanes, with o=addr[1:0]:
  - sb: be = 0001<<o, wdata byte replicated to the lane by <<8*o.
  - sh: be = 0011<<(2*addr[1]), data <<16*addr[1].
  - sw: be = 1111, data unshifted.
- Load extraction:
  - Select the byte at o, or the half at addr[1], from dmem_rdata.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes the word through.
  - Undefined funct3 values (011, 110, 111) are treated as lw/sw.
- stall_count increments each cycle stall=1 and saturates at all-ones (no wrap).
- load_data holds its value outside DONE; consumers use it only in DONE.

Test Plan:
- sw addr=0x100, wdata=0xDEADBEEF, resp after 3 cycles -> dmem_write=1 with be=1111 and dmem_address=0x100 held for 3 cycles; stall high 4 cycles; DONE with stall=0; stall_count=4.
- lb addr=0x203, dmem_rdata=0x80FF1234 -> dmem_address=0x200; load_data=0xFFFFFF80. Repeat as lbu -> 0x00000080.
- sh addr=0x302, wdata=0x0000ABCD -> be=1100, dmem_wdata=0xABCD0000. lhu addr=0x302 with rdata=0xF00D0000 -> load_data=0x0000F00D.
- lw addr=0x101 -> no dmem_read ever asserted; misaligned pulse for one cycle; stall high 1 cycle; load_data=0.
- rst asserted mid-BUSY (dmem_read=1) -> dmem_read=0 immediately, state IDLE. A stray dmem_resp afterwards is ignored, and a fresh lw completes normally.
- mem_read and mem_write both high with sw addr=0x40 -> dmem_write=1 and dmem_read=0. A dmem_resp during IDLE changes nothing.
